// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: S/Cout combinational; registered copy with flags one cycle later.
// No backpressure: capture is gated only by en, and valid_q marks the cycle after a capture.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             en,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q,
    output logic             Ovf_q,
    output logic             Zero_q,
    output logic             valid_q
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             w_ovf;
    logic             w_zero;

    logic [WIDTH-1:0] r_s_q;
    logic             r_cout_q;
    logic             r_ovf_q;
    logic             r_zero_q;
    logic             r_valid_q;

    assign w_c[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign w_s[i]   = A[i] ^ B[i] ^ w_c[i];
            assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    endgenerate

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign w_ovf  = w_c[WIDTH-1] ^ w_c[WIDTH];
    assign w_zero = (w_s == '0);

    assign S    = w_s;
    assign Cout = w_c[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q     <= '0;
            r_cout_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_zero_q  <= 1'b0;
            r_valid_q <= 1'b0;
        end else if (en) begin
            r_s_q     <= w_s;
            r_cout_q  <= w_c[WIDTH];
            r_ovf_q   <= w_ovf;
            r_zero_q  <= w_zero;
            r_valid_q <= 1'b1;
        end else begin
            r_valid_q <= 1'b0;
        end
    end

    assign S_q     = r_s_q;
    assign Cout_q  = r_cout_q;
    assign Ovf_q   = r_ovf_q;
    assign Zero_q  = r_zero_q;
    assign valid_q = r_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1, 8 and 16: vector tables, hand sequences and a random model check.
module tb_full_adder;

    logic clk;
    logic rst_n;

    logic       a1, b1, cin1, en1;
    logic       s1, cout1, s1_q, cout1_q, ovf1_q, zero1_q, valid1_q;

    logic [7:0] a8, b8, s8, s8_q;
    logic       cin8, en8, cout8, cout8_q, ovf8_q, zero8_q, valid8_q;

    logic [15:0] a16, b16, s16, s16_q;
    logic        cin16, en16, cout16, cout16_q, ovf16_q, zero16_q, valid16_q;

    int n_cmp = 0;
    int n_err = 0;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .en(en1),
        .S(s1), .Cout(cout1), .S_q(s1_q), .Cout_q(cout1_q), .Ovf_q(ovf1_q),
        .Zero_q(zero1_q), .valid_q(valid1_q)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .en(en8),
        .S(s8), .Cout(cout8), .S_q(s8_q), .Cout_q(cout8_q), .Ovf_q(ovf8_q),
        .Zero_q(zero8_q), .valid_q(valid8_q)
    );

    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .en(en16),
        .S(s16), .Cout(cout16), .S_q(s16_q), .Cout_q(cout16_q), .Ovf_q(ovf16_q),
        .Zero_q(zero16_q), .valid_q(valid16_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic a, b, cin;
        logic s, cout;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] s;
        logic       cout, ovf, zero;
    } vec8_t;

    vec1_t v1[8];
    vec8_t v8[4];

    // Reference: plain wide arithmetic plus the signed-operand overflow rule.
    logic [16:0] m_sum;
    logic [15:0] m_s_q;
    logic        m_cout_q, m_ovf_q, m_zero_q, m_valid_q;
    logic        m_ovf;

    initial begin
        v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        v8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        v8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        v8[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; en1 = 0;
        a8 = 0; b8 = 0; cin8 = 0; en8 = 0;
        a16 = 0; b16 = 0; cin16 = 0; en16 = 0;

        #2;
        chk("reset S8_q", s8_q, 0);
        chk("reset Cout8_q", cout8_q, 0);
        chk("reset Ovf8_q", ovf8_q, 0);
        chk("reset Zero8_q", zero8_q, 0);
        chk("reset valid8_q", valid8_q, 0);
        chk("reset valid16_q", valid16_q, 0);

        // One-bit exhaustive, purely combinational (registers held in reset).
        for (int i = 0; i < 8; i++) begin
            a1 = v1[i].a; b1 = v1[i].b; cin1 = v1[i].cin;
            #10;
            chk($sformatf("w1 S[%0d]", i), s1, v1[i].s);
            chk($sformatf("w1 Cout[%0d]", i), cout1, v1[i].cout);
        end

        @(negedge clk);
        rst_n = 1'b1;

        // One-bit capture: -1 + -1 overflows in a 1-bit signed field.
        a1 = 1; b1 = 1; cin1 = 0; en1 = 1;
        @(posedge clk); #1;
        chk("w1 S_q", s1_q, 0);
        chk("w1 Cout_q", cout1_q, 1);
        chk("w1 Ovf_q", ovf1_q, 1);
        chk("w1 Zero_q", zero1_q, 1);
        chk("w1 valid_q", valid1_q, 1);
        en1 = 0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].cin; en8 = 1;
            #1;
            chk($sformatf("w8 S[%0d]", i), s8, v8[i].s);
            chk($sformatf("w8 Cout[%0d]", i), cout8, v8[i].cout);
            @(posedge clk); #1;
            chk($sformatf("w8 S_q[%0d]", i), s8_q, v8[i].s);
            chk($sformatf("w8 Cout_q[%0d]", i), cout8_q, v8[i].cout);
            chk($sformatf("w8 Ovf_q[%0d]", i), ovf8_q, v8[i].ovf);
            chk($sformatf("w8 Zero_q[%0d]", i), zero8_q, v8[i].zero);
            chk($sformatf("w8 valid_q[%0d]", i), valid8_q, 1);
        end

        // Hold: en low, inputs change, registers keep 7.
        @(negedge clk);
        en8 = 0; a8 = 8'd1; b8 = 8'd1;
        #1;
        chk("hold S comb", s8, 8'd2);
        chk("hold S_q pre-edge", s8_q, 8'd7);
        @(posedge clk); #1;
        chk("hold S_q", s8_q, 8'd7);
        chk("hold valid_q", valid8_q, 0);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst S_q", s8_q, 0);
        chk("arst Cout_q", cout8_q, 0);
        chk("arst Ovf_q", ovf8_q, 0);
        chk("arst Zero_q", zero8_q, 0);
        chk("arst valid_q", valid8_q, 0);
        chk("arst S comb", s8, 8'd2);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'd5; b8 = 8'd6; en8 = 1;
        @(posedge clk); #1;
        chk("post-rst S_q", s8_q, 8'd11);
        chk("post-rst valid_q", valid8_q, 1);
        en8 = 0;

        // Randomised 16-bit run; registers start cleared by the reset above.
        m_s_q = 0; m_cout_q = 0; m_ovf_q = 0; m_zero_q = 0; m_valid_q = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            en16  = ($urandom_range(0, 3) != 0);
            m_sum = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
            m_ovf = (a16[15] == b16[15]) && (m_sum[15] != a16[15]);
            #1;
            chk("rnd S", s16, m_sum[15:0]);
            chk("rnd Cout", cout16, m_sum[16]);
            if (en16) begin
                m_s_q    = m_sum[15:0];
                m_cout_q = m_sum[16];
                m_ovf_q  = m_ovf;
                m_zero_q = (m_sum[15:0] == 0);
            end
            m_valid_q = en16;
            @(posedge clk); #1;
            chk("rnd S_q", s16_q, m_s_q);
            chk("rnd Cout_q", cout16_q, m_cout_q);
            chk("rnd Ovf_q", ovf16_q, m_ovf_q);
            chk("rnd Zero_q", zero16_q, m_zero_q);
            chk("rnd valid_q", valid16_q, m_valid_q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
